// File: rtl/tx_write_arbiter.sv
// Round-robin arbiter sharing the single TX FIFO write port among NUM_REQ byte producers.
// Each grant allows a bounded burst, and no write is issued while the FIFO is full.
module tx_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   input  logic                   fifo_full,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   write_enable,
   output logic [7:0]             write_data,
   output logic                   busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, HOLD, WR} state_t;

   state_t             state_reg;
   logic [IW-1:0]      owner_reg;
   logic [IW-1:0]      ptr_reg;
   logic [CW-1:0]      burst_reg;
   logic               last_reg;
   logic [NUM_REQ-1:0] grant_reg;
   logic [NUM_REQ-1:0] ack_reg;
   logic               we_reg;
   logic               busy_reg;
   logic [7:0]         wdata_reg;

   logic [7:0]         req_byte [NUM_REQ];
   logic [IW-1:0]      sel_next;
   logic               sel_valid_next;
   logic [IW-1:0]      cand_next;
   logic [IW-1:0]      ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_byte[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   // Scan from the far end back toward the pointer so the closest active requester wins.
   always_comb begin
      sel_next       = '0;
      sel_valid_next = 1'b0;
      cand_next      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_next = IW'((int'(ptr_reg) + k) % NUM_REQ);
         if (req[cand_next]) begin
            sel_next       = cand_next;
            sel_valid_next = 1'b1;
         end
      end
   end

   assign ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         ptr_reg   <= '0;
         burst_reg <= '0;
         last_reg  <= 1'b0;
         grant_reg <= '0;
         ack_reg   <= '0;
         we_reg    <= 1'b0;
         busy_reg  <= 1'b0;
         wdata_reg <= 8'h00;
      end else begin
         we_reg  <= 1'b0;
         ack_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (sel_valid_next) begin
                  owner_reg <= sel_next;
                  grant_reg <= NUM_REQ'(1) << sel_next;
                  burst_reg <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (!req[owner_reg]) begin
                  ptr_reg   <= ptr_next;
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (!fifo_full) begin
                  wdata_reg <= req_byte[owner_reg];
                  last_reg  <= req_last[owner_reg];
                  burst_reg <= burst_reg + 1'b1;
                  we_reg    <= 1'b1;
                  ack_reg   <= grant_reg;
                  state_reg <= WR;
               end
            end
            WR: begin
               // burst_reg already counts the byte being written this cycle
               if (last_reg || burst_reg == BURST_MAX) begin
                  ptr_reg   <= ptr_next;
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  state_reg <= HOLD;
               end
            end
            default: begin
               grant_reg <= '0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign grant        = grant_reg;
   assign ack          = ack_reg;
   assign write_enable = we_reg;
   assign write_data   = wdata_reg;
   assign busy         = busy_reg;
endmodule

// File: tb/tb_tx_write_arbiter.sv
// Directed bench for tx_write_arbiter: a cycle vector table plus hand-written
// sequences for round-robin, burst limit, back-pressure, withdrawal and reset.
module tb_tx_write_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           n_rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic           fifo_full;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic           write_enable;
   logic [7:0]     write_data;
   logic           busy;

   int n_cmp = 0;
   int n_bad = 0;

   tx_write_arbiter #(.NUM_REQ(N), .MAX_BURST(8)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req          (req),
      .req_data     (req_data),
      .req_last     (req_last),
      .fifo_full    (fifo_full),
      .ack          (ack),
      .grant        (grant),
      .write_enable (write_enable),
      .write_data   (write_data),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  req;
      logic [3:0]  last;
      logic [31:0] data;
      logic        ff;
      logic [3:0]  e_grant;
      logic [3:0]  e_ack;
      logic        e_we;
      logic [7:0]  e_wdata;
      logic        e_busy;
   } vec_t;

   task automatic check_outs(input string name, input logic [3:0] eg, input logic [3:0] ea,
                             input logic ew, input logic [7:0] ed, input logic eb);
      n_cmp++;
      if ({grant, ack, write_enable, write_data, busy} !== {eg, ea, ew, ed, eb}) begin
         n_bad++;
         $display("FAIL %s: got grant=%b ack=%b we=%b wdata=%h busy=%b, want grant=%b ack=%b we=%b wdata=%h busy=%b",
                  name, grant, ack, write_enable, write_data, busy, eg, ea, ew, ed, eb);
      end else begin
         $display("ok   %s: grant=%b ack=%b we=%b wdata=%h busy=%b",
                  name, grant, ack, write_enable, write_data, busy);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d, input logic ff);
      req       = r;
      req_last  = l;
      req_data  = d;
      fifo_full = ff;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      n_rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   function automatic int owner_of(input logic [3:0] g);
      int o;
      o = -1;
      for (int k = 0; k < N; k++) if (g[k]) o = k;
      return o;
   endfunction

   vec_t vecs [11];

   initial begin
      // single requester two-byte burst, then a pointer check with requesters 0 and 1
      vecs[0]  = '{4'b0001, 4'b0000, 32'h000000A1, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1};
      vecs[1]  = '{4'b0001, 4'b0000, 32'h000000A1, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA1, 1'b1};
      vecs[2]  = '{4'b0001, 4'b0001, 32'h000000A2, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA1, 1'b1};
      vecs[3]  = '{4'b0001, 4'b0001, 32'h000000A2, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA2, 1'b1};
      vecs[4]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA2, 1'b0};
      vecs[5]  = '{4'b0011, 4'b0011, 32'h0000B1B0, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'hA2, 1'b1};
      vecs[6]  = '{4'b0011, 4'b0011, 32'h0000B1B0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hB1, 1'b1};
      vecs[7]  = '{4'b0001, 4'b0001, 32'h0000B1B0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b0};
      vecs[8]  = '{4'b0001, 4'b0001, 32'h0000B1B0, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hB1, 1'b1};
      vecs[9]  = '{4'b0001, 4'b0001, 32'h0000B1B0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hB0, 1'b1};
      vecs[10] = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hB0, 1'b0};

      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      n_rst = 1'b0;
      #12;
      check_outs("reset_state", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;

      for (int v = 0; v < 11; v++) begin
         drive(vecs[v].req, vecs[v].last, vecs[v].data, vecs[v].ff);
         step();
         check_outs($sformatf("vec%0d", v), vecs[v].e_grant, vecs[v].e_ack,
                    vecs[v].e_we, vecs[v].e_wdata, vecs[v].e_busy);
      end

      // round-robin, one byte each, busy low for one cycle between grants
      begin
         int order [5];
         logic [7:0] prev_wd;
         logic [7:0] bt;
         logic [3:0] oh;
         order = '{0, 1, 2, 3, 0};
         apply_reset();
         drive(4'b1111, 4'b1111, 32'h40302010, 1'b0);
         prev_wd = 8'h00;
         for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order[i];
            bt = 8'((order[i] + 1) * 16);
            step(); check_outs($sformatf("rr%0d_hold", i), oh, 4'b0000, 1'b0, prev_wd, 1'b1);
            step(); check_outs($sformatf("rr%0d_wr", i), oh, oh, 1'b1, bt, 1'b1);
            step(); check_outs($sformatf("rr%0d_idle", i), 4'b0000, 4'b0000, 1'b0, bt, 1'b0);
            prev_wd = bt;
         end
      end

      // burst limit: requester 2 streams 12 bytes, requester 3 has one byte
      begin
         int b2;
         bit done3;
         int nw;
         int own;
         bit finished;
         logic [31:0] exp_w [13];
         for (int i = 0; i < 8; i++) exp_w[i] = {24'd2, 8'(i)};
         exp_w[8] = {24'd3, 8'h33};
         for (int i = 9; i < 13; i++) exp_w[i] = {24'd2, 8'(i - 1)};
         apply_reset();
         b2 = 0; done3 = 1'b0; nw = 0; finished = 1'b0;
         for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            drive({!done3, b2 < 12, 2'b00}, {1'b1, b2 == 11, 2'b00},
                  {8'h33, 8'(b2), 16'h0000}, 1'b0);
            step();
            if (write_enable) begin
               own = owner_of(grant);
               if (nw < 13) check_val($sformatf("burst_w%0d", nw), {24'(own), write_data}, exp_w[nw]);
               else check_val("burst_extra_write", {24'(own), write_data}, 32'hFFFF_FFFF);
               nw++;
            end
            if (ack[2]) b2++;
            if (ack[3]) done3 = 1'b1;
            if (b2 == 12 && done3 && !busy) finished = 1'b1;
         end
         check_val("burst_done", {31'd0, finished}, 32'd1);
         check_val("burst_count", 32'(nw), 32'd13);
      end

      // back-pressure: fifo_full held while requester 1 waits in HOLD
      apply_reset();
      drive(4'b0010, 4'b0010, 32'h00005500, 1'b1);
      step(); check_outs("bp_grant", 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(); check_outs($sformatf("bp_hold%0d", i), 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1);
      end
      fifo_full = 1'b0;
      step(); check_outs("bp_write", 4'b0010, 4'b0010, 1'b1, 8'h55, 1'b1);
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      step(); check_outs("bp_idle", 4'b0000, 4'b0000, 1'b0, 8'h55, 1'b0);

      // withdrawal in HOLD hands over to the pending requester
      drive(4'b0011, 4'b0011, 32'h00006160, 1'b0);
      step(); check_outs("wd_hold0", 4'b0001, 4'b0000, 1'b0, 8'h55, 1'b1);
      drive(4'b0010, 4'b0011, 32'h00006160, 1'b0);
      step(); check_outs("wd_release", 4'b0000, 4'b0000, 1'b0, 8'h55, 1'b0);
      step(); check_outs("wd_hold1", 4'b0010, 4'b0000, 1'b0, 8'h55, 1'b1);
      step(); check_outs("wd_write1", 4'b0010, 4'b0010, 1'b1, 8'h61, 1'b1);
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      step(); check_outs("wd_idle", 4'b0000, 4'b0000, 1'b0, 8'h61, 1'b0);

      // reset during WR clears outputs at once and restarts arbitration from requester 0
      drive(4'b0100, 4'b0000, 32'h00770000, 1'b0);
      step(); check_outs("rst_hold", 4'b0100, 4'b0000, 1'b0, 8'h61, 1'b1);
      step(); check_outs("rst_wr", 4'b0100, 4'b0100, 1'b1, 8'h77, 1'b1);
      #2;
      n_rst = 1'b0;
      #1;
      check_outs("rst_async", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
      drive(4'b0111, 4'b0111, 32'h00999190, 1'b0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      step(); check_outs("rst_regrant", 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1);
      step(); check_outs("rst_write", 4'b0001, 4'b0001, 1'b1, 8'h90, 1'b1);
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      step(); check_outs("rst_idle", 4'b0000, 4'b0000, 1'b0, 8'h90, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
